merge_rr: RTL and testbench



---
 rtl/merge_rr_pkg.sv | 33 +++
 rtl/merge_rr_rr_arbiter.sv | 43 ++++
 rtl/merge_rr.sv | 100 ++++++++++
 tb/tb_merge_rr.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_rr_pkg.sv
// ============================================================================
// merge_rr_pkg : shared types, widths and bit positions for merge_rr. Rev 1.0
// ============================================================================
`default_nettype none

package merge_rr_pkg;

  localparam logic c_ST_IDLE   = 1'b0;
  localparam logic c_ST_BUSY   = 1'b1;
  localparam int   c_READY_BIT = 0;

  typedef enum logic [0:0] {
    ST_IDLE = c_ST_IDLE,
    ST_BUSY = c_ST_BUSY
  } state_t;

  // IOb native request layout: {valid, addr, wdata, wstrb}, valid at the MSB.
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // IOb native response layout: {rdata, ready}, ready at bit 0.
  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int valid_bit(input int req_w);
    return req_w - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/merge_rr_rr_arbiter.sv
// ============================================================================
// merge_rr_rr_arbiter : combinational round-robin pick starting at i_ptr. Rev 1.0
// ============================================================================
`default_nettype none

module merge_rr_rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_gnt_idx,
  output logic             o_any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [PTR_W:0] w_sum;

  // Rotating the doubled vector puts the ptr'th request at bit 0.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    o_any     = 1'b0;
    o_gnt_idx = '0;
    w_sum     = '0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any = 1'b1;
        w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(k);
        // Explicit wrap so non-power-of-two N never lands on an invalid index.
        if (w_sum >= (PTR_W + 1)'(N)) begin
          w_sum = w_sum - (PTR_W + 1)'(N);
        end
        o_gnt_idx = w_sum[PTR_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/merge_rr.sv
// ============================================================================
// merge_rr : N-to-1 round-robin IOb request merger, grant held to ready. Rev 1.0
// ============================================================================
`default_nettype none

module merge_rr
  import merge_rr_pkg::*;
#(
  parameter int  N_MASTERS = 2,
  parameter int  ADDR_W    = 32,
  parameter int  DATA_W    = 32,
  localparam int REQ_W     = req_width(ADDR_W, DATA_W),
  localparam int RESP_W    = resp_width(DATA_W),
  localparam int PTR_W     = $clog2(N_MASTERS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_MASTERS*REQ_W-1:0]  m_req,
  output logic [N_MASTERS*RESP_W-1:0] m_resp,
  output logic [REQ_W-1:0]            s_req,
  input  logic [RESP_W-1:0]           s_resp
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PTR_W-1:0]     r_gnt;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     w_gnt_nxt;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic [N_MASTERS-1:0] w_valid;
  logic [N_MASTERS-1:0] w_own;
  logic [PTR_W-1:0]     w_win;
  logic                 w_any;
  logic [REQ_W-1:0]     w_sel_req;

  generate
    for (genvar i = 0; i < N_MASTERS; i++) begin : g_master
      assign w_valid[i] = m_req[i*REQ_W + valid_bit(REQ_W)];
      assign w_own[i]   = (r_state == ST_BUSY) && (r_gnt == PTR_W'(i));
      assign m_resp[i*RESP_W +: RESP_W] = w_own[i] ? s_resp : '0;
    end
  endgenerate

  always_comb begin
    w_sel_req = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_own[i]) begin
        w_sel_req = m_req[i*REQ_W +: REQ_W];
      end
    end
  end

  assign s_req = w_sel_req;

  merge_rr_rr_arbiter #(
    .N     (N_MASTERS),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req     (w_valid),
    .i_ptr     (r_ptr),
    .o_gnt_idx (w_win),
    .o_any     (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = w_win;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_resp[c_READY_BIT]) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = (r_gnt == PTR_W'(N_MASTERS - 1)) ? '0 : r_gnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_merge_rr.sv
// ============================================================================
// tb_merge_rr : self-checking bench for merge_rr (N=2 and N=3 instances). Rev 1.0
// ============================================================================
`default_nettype none

module tb_merge_rr;

  localparam int A2  = 32;
  localparam int D2  = 32;
  localparam int RQ2 = 1 + A2 + D2 + D2/8;
  localparam int RS2 = D2 + 1;
  localparam int N3  = 3;
  localparam int A3  = 16;
  localparam int D3  = 16;
  localparam int RQ3 = 1 + A3 + D3 + D3/8;
  localparam int RS3 = D3 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [2*RQ2-1:0]  m_req2 = '0;
  logic [2*RS2-1:0]  m_resp2;
  logic [RQ2-1:0]    s_req2;
  logic [RS2-1:0]    s_resp2 = '0;
  logic [N3*RQ3-1:0] m_req3 = '0;
  logic [N3*RS3-1:0] m_resp3;
  logic [RQ3-1:0]    s_req3;
  logic [RS3-1:0]    s_resp3 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  merge_rr #(.N_MASTERS(2), .ADDR_W(A2), .DATA_W(D2)) dut2 (
    .clk(clk), .rst_n(rst_n), .m_req(m_req2), .m_resp(m_resp2),
    .s_req(s_req2), .s_resp(s_resp2)
  );

  merge_rr #(.N_MASTERS(N3), .ADDR_W(A3), .DATA_W(D3)) dut3 (
    .clk(clk), .rst_n(rst_n), .m_req(m_req3), .m_resp(m_resp3),
    .s_req(s_req3), .s_resp(s_resp3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] valid;
    int         exp_gnt;
  } vec_t;

  typedef struct {
    logic [RQ3-1:0] req;
    int             gnt;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [RQ2-1:0] req2(input logic v, input logic [A2-1:0] a,
                                          input logic [D2-1:0] d, input logic [D2/8-1:0] s);
    return {v, a, d, s};
  endfunction

  function automatic logic [RQ3-1:0] req3(input int m, input logic v);
    return {v, 16'(16'h1000 + m), 16'(16'hA5A0 + m), 2'(m + 1)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t              vecs[12];
    exp_t              ent;
    int                waited;
    logic [D3-1:0]     rd;
    logic [N3*RS3-1:0] exp_resp;
    logic [RQ2-1:0]    ra;
    logic [RQ2-1:0]    rb;

    vecs[0]  = '{valid: 3'b111, exp_gnt: 0};
    vecs[1]  = '{valid: 3'b111, exp_gnt: 1};
    vecs[2]  = '{valid: 3'b111, exp_gnt: 2};
    vecs[3]  = '{valid: 3'b111, exp_gnt: 0};
    vecs[4]  = '{valid: 3'b111, exp_gnt: 1};
    vecs[5]  = '{valid: 3'b111, exp_gnt: 2};
    vecs[6]  = '{valid: 3'b010, exp_gnt: 1};
    vecs[7]  = '{valid: 3'b001, exp_gnt: 0};
    vecs[8]  = '{valid: 3'b101, exp_gnt: 2};
    vecs[9]  = '{valid: 3'b110, exp_gnt: 1};
    vecs[10] = '{valid: 3'b011, exp_gnt: 0};
    vecs[11] = '{valid: 3'b100, exp_gnt: 2};

    // Reset, then idle with no valid for 10 cycles.
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_sreq2", 256'(s_req2), 256'(0));
      check("idle_mresp2", 256'(m_resp2), 256'(0));
      check("idle_sreq3", 256'(s_req3), 256'(0));
      check("idle_mresp3", 256'(m_resp3), 256'(0));
    end

    // Round-robin table on the 3-master instance.
    for (int v = 0; v < 12; v++) begin
      for (int m = 0; m < N3; m++) m_req3[m*RQ3 +: RQ3] = req3(m, vecs[v].valid[m]);
      s_resp3 = '0;
      ent.req = req3(vecs[v].exp_gnt, 1'b1);
      ent.gnt = vecs[v].exp_gnt;
      sbq.push_back(ent);
      waited = 0;
      do begin
        tick();
        waited++;
      end while (s_req3[RQ3-1] !== 1'b1 && waited < 4);
      check($sformatf("rr%0d_latency", v), 256'(waited), 256'(1));
      if (sbq.size() > 0) begin
        ent = sbq.pop_front();
        check($sformatf("rr%0d_sreq", v), 256'(s_req3), 256'(ent.req));
        rd = 16'(16'h3C00 + v);
        s_resp3 = {rd, 1'b1};
        #1;
        exp_resp = '0;
        exp_resp[ent.gnt*RS3 +: RS3] = {rd, 1'b1};
        check($sformatf("rr%0d_mresp", v), 256'(m_resp3), 256'(exp_resp));
      end
      tick();
      s_resp3 = '0;
      #1;
      check($sformatf("rr%0d_bubble", v), 256'(s_req3), 256'(0));
    end
    m_req3 = '0;

    // Single master: master 1 on the 2-master instance.
    ra = req2(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    m_req2 = {ra, RQ2'(0)};
    tick();
    check("sm_sreq", 256'(s_req2), 256'(ra));
    check("sm_mresp_wait", 256'(m_resp2), 256'(0));
    s_resp2 = {32'h12345678, 1'b1};
    #1;
    check("sm_mresp", 256'(m_resp2), 256'({32'h12345678, 1'b1, RS2'(0)}));
    tick();
    m_req2 = '0;
    s_resp2 = '0;
    #1;
    check("sm_idle", 256'(s_req2), 256'(0));

    // Grant hold: master 0 owns the slave for 5 cycles while master 1 waits.
    ra = req2(1'b1, 32'h200, 32'h11111111, 4'h3);
    rb = req2(1'b1, 32'h300, 32'h22222222, 4'hC);
    m_req2 = {rb, ra};
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d_sreq", c), 256'(s_req2), 256'(ra));
      check($sformatf("hold%0d_mresp", c), 256'(m_resp2), 256'(0));
      tick();
    end
    s_resp2 = {32'hCAFEF00D, 1'b1};
    #1;
    check("hold_mresp0", 256'(m_resp2), 256'({RS2'(0), 32'hCAFEF00D, 1'b1}));
    tick();
    m_req2 = {rb, RQ2'(0)};
    s_resp2 = '0;
    #1;
    check("hold_bubble", 256'(s_req2), 256'(0));
    tick();
    check("hold_next_sreq", 256'(s_req2), 256'(rb));
    s_resp2 = {32'h0BADF00D, 1'b1};
    #1;
    check("hold_mresp1", 256'(m_resp2), 256'({32'h0BADF00D, 1'b1, RS2'(0)}));
    tick();
    m_req2 = '0;
    s_resp2 = '0;

    // Move ptr to 1 with a master-0 transaction, then reset mid-BUSY.
    m_req2 = {RQ2'(0), ra};
    tick();
    s_resp2 = {32'h1, 1'b1};
    #1;
    check("pre_mresp0", 256'(m_resp2), 256'({RS2'(0), 32'h1, 1'b1}));
    tick();
    s_resp2 = '0;
    m_req2 = {RQ2'(0), ra};
    tick();
    check("arst_busy_sreq", 256'(s_req2), 256'(ra));
    #1 rst_n = 1'b0;
    s_resp2 = {32'h55, 1'b1};
    #1;
    check("arst_sreq", 256'(s_req2), 256'(0));
    check("arst_mresp", 256'(m_resp2), 256'(0));
    s_resp2 = '0;
    m_req2 = {rb, ra};
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_ptr0_win", 256'(s_req2), 256'(ra));
    s_resp2 = {32'h77, 1'b1};
    tick();
    m_req2 = '0;
    s_resp2 = '0;
    tick();

    // Spurious ready while IDLE.
    s_resp2 = {32'hFFFFFFFF, 1'b1};
    #1;
    check("spur_mresp", 256'(m_resp2), 256'(0));
    tick();
    check("spur_sreq", 256'(s_req2), 256'(0));
    check("spur_mresp_next", 256'(m_resp2), 256'(0));
    s_resp2 = '0;
    m_req2 = {rb, RQ2'(0)};
    tick();
    check("spur_then_grant", 256'(s_req2), 256'(rb));
    s_resp2 = {32'h9, 1'b1};
    tick();
    m_req2 = '0;
    s_resp2 = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
